// File: rtl/falling_byte_column.sv
// rtl/falling_byte_column.sv - one falling-target game column with LFSR spawn and hit detection
module falling_byte_column #(
    parameter int          ROWS          = 20,
    parameter int          FALL_TICKS    = 4,
    parameter int          RESPAWN_TICKS = 2,
    parameter logic [7:0]  SEED          = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       run,
    input  logic [7:0] user_input,
    input  logic       submit,
    output logic [4:0] ypos,
    output logic [7:0] letter,
    output logic       active,
    output logic       correct,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_FALL  = 3'd2,
        S_GAP   = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int MAX_T = (FALL_TICKS > RESPAWN_TICKS) ? FALL_TICKS : RESPAWN_TICKS;
    localparam int CNT_W = $clog2(MAX_T + 1);

    localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(FALL_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RESPAWN_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [4:0]       LAST_ROW  = 5'(ROWS - 1);
    localparam logic [7:0]       LFSR_MASK = 8'hB8;

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [4:0]       ypos_q, ypos_d;
    logic [7:0]       letter_q, letter_d;
    logic             active_q, active_d;
    logic             correct_q, correct_d;
    logic             over_q, over_d;
    logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             submit_q;

    // A held submit only counts on its first cycle.
    logic submit_edge;
    assign submit_edge = submit && !submit_q;

    // State register, LFSR and all column outputs; async reset to the idle column.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED;
            ypos_q     <= 5'd0;
            letter_q   <= 8'h00;
            active_q   <= 1'b0;
            correct_q  <= 1'b0;
            over_q     <= 1'b0;
            fall_cnt_q <= '0;
            gap_cnt_q  <= '0;
            submit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            ypos_q     <= ypos_d;
            letter_q   <= letter_d;
            active_q   <= active_d;
            correct_q  <= correct_d;
            over_q     <= over_d;
            fall_cnt_q <= fall_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            submit_q   <= submit;
        end
    end

    // Next-state logic: spawn, fall with hit-before-drop priority, respawn gap, terminal over.
    always_comb begin
        state_d    = state_q;
        ypos_d     = ypos_q;
        letter_d   = letter_q;
        active_d   = active_q;
        correct_d  = 1'b0;
        over_d     = over_q;
        fall_cnt_d = fall_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        // Galois step runs every clock so spawn values depend on player timing.
        lfsr_d     = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_MASK : 8'h00);

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_SPAWN;
                end
            end
            S_SPAWN: begin
                letter_d   = lfsr_q;
                ypos_d     = 5'd0;
                active_d   = 1'b1;
                fall_cnt_d = '0;
                state_d    = S_FALL;
            end
            S_FALL: begin
                if (run && submit_edge && (user_input == letter_q)) begin
                    correct_d = 1'b1;
                    active_d  = 1'b0;
                    letter_d  = 8'h00;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else if (tick && run) begin
                    if (fall_cnt_q == FALL_LAST) begin
                        fall_cnt_d = '0;
                        if (ypos_q == LAST_ROW) begin
                            over_d   = 1'b1;
                            active_d = 1'b0;
                            letter_d = 8'h00;
                            state_d  = S_OVER;
                        end else begin
                            ypos_d = ypos_q + 5'd1;
                        end
                    end else begin
                        fall_cnt_d = fall_cnt_q + CNT_ONE;
                    end
                end
            end
            S_GAP: begin
                if (tick && run) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = '0;
                        state_d   = S_SPAWN;
                    end else begin
                        gap_cnt_d = gap_cnt_q + CNT_ONE;
                    end
                end
            end
            S_OVER: begin
                over_d   = 1'b1;
                letter_d = 8'h00;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ypos      = ypos_q;
    assign letter    = letter_q;
    assign active    = active_q;
    assign correct   = correct_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_falling_byte_column.sv
// tb/tb_falling_byte_column.sv - scoreboard bench for falling_byte_column
module tb_falling_byte_column;

    logic       clock;
    logic       reset;
    logic       tick;
    logic       run;
    logic [7:0] user_input;
    logic       submit;
    logic [4:0] ypos;
    logic [7:0] letter;
    logic       active;
    logic       correct;
    logic       game_over;

    falling_byte_column #(
        .ROWS(20), .FALL_TICKS(4), .RESPAWN_TICKS(2), .SEED(8'hA5)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick), .run(run),
        .user_input(user_input), .submit(submit), .ypos(ypos),
        .letter(letter), .active(active), .correct(correct),
        .game_over(game_over)
    );

    localparam int EV_SPAWN   = 0;
    localparam int EV_CORRECT = 1;
    localparam int EV_OVER    = 2;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    logic [7:0] model_lfsr;
    logic [7:0] saved_letter;
    logic       act_prev = 1'b0;
    logic       go_prev  = 1'b0;
    logic       found;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {1'b0, x[7:1]} ^ (x[0] ? 8'hB8 : 8'h00);
    endfunction

    // Reference LFSR: free-running sequence seeded by reset.
    always @(posedge clock or posedge reset) begin
        if (reset) model_lfsr <= 8'hA5;
        else       model_lfsr <= lfsr_step(model_lfsr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_evt(input int kind, input logic [7:0] val);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d value %0h expected no event", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.val === val) passed++;
            else $display("FAIL event: got kind %0d value %0h expected kind %0d value %0h",
                          kind, val, e.kind, e.val);
        end
    endtask

    // Monitor: pops the scoreboard on spawn, hit and game-over events.
    always @(negedge clock) begin
        if (!reset) begin
            if (active && !act_prev) begin
                if (ypos !== 5'd0) check_evt(EV_SPAWN, 8'hFF);
                else               check_evt(EV_SPAWN, letter);
            end
            if (correct) check_evt(EV_CORRECT, 8'h00);
            if (game_over && !go_prev) begin
                if (active !== 1'b0 || letter !== 8'h00) check_evt(EV_OVER, 8'hFF);
                else                                     check_evt(EV_OVER, {3'b000, ypos});
            end
        end
        act_prev = active;
        go_prev  = game_over;
    end

    task automatic push(input int kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
    endtask

    task automatic pulse_submit(input logic [7:0] val);
        user_input = val;
        submit     = 1'b1;
        cyc();
        submit     = 1'b0;
    endtask

    // Reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        chk({tag, "_ypos"}, ypos, 0);
        chk({tag, "_letter"}, letter, 0);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_correct"}, correct, 0);
        chk({tag, "_game_over"}, game_over, 0);
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; tick = 1'b0; run = 1'b1; user_input = 8'h00; submit = 1'b0;
        cyc();

        // Reset, then spawn of the first LFSR step after SEED (A5 -> EA).
        do_reset("rst0");
        cyc();
        chk("spawn_cycle_active", active, 0);
        push(EV_SPAWN, 8'hEA);
        cyc();
        chk("t1_active", active, 1);
        chk("t1_ypos", ypos, 0);
        chk("t1_letter", letter, 8'hEA);
        chk("t1_game_over", game_over, 0);

        // Fall all the way down: 4 ticks per row, 80 ticks to fall off row 19.
        do_ticks(4);
        chk("t2_ypos1", ypos, 1);
        do_ticks(72);
        chk("t2_ypos19", ypos, 19);
        push(EV_OVER, 8'd19);
        do_ticks(4);
        chk("t2_game_over", game_over, 1);
        chk("t2_active", active, 0);
        chk("t2_letter", letter, 0);
        chk("t2_ypos_hold", ypos, 19);
        pulse_submit(8'hEA);
        do_ticks(5);
        chk("t2_over_sticky", game_over, 1);
        chk("t2_over_ypos", ypos, 19);
        chk("t2_over_letter", letter, 0);

        // Asynchronous reset out of OVER restores SEED: next spawn is EA again.
        do_reset("rst_over");
        cyc();
        push(EV_SPAWN, 8'hEA);
        cyc();
        chk("t6_reseed_letter", letter, 8'hEA);

        // Pause at row 5 mid-count; matching submit ignored while paused.
        do_ticks(22);
        chk("t5_ypos5", ypos, 5);
        run = 1'b0;
        do_ticks(10);
        chk("t5_frozen", ypos, 5);
        pulse_submit(8'hEA);
        chk("t5_no_hit_paused", correct, 0);
        chk("t5_still_active", active, 1);
        run = 1'b1;
        do_ticks(1);
        chk("t5_resume_cnt3", ypos, 5);
        do_ticks(1);
        chk("t5_resume_drop", ypos, 6);
        push(EV_CORRECT, 8'h00);
        pulse_submit(8'hEA);
        chk("t5_hit", correct, 1);
        chk("t5_hit_letter", letter, 0);
        cyc();
        do_ticks(1);

        // Asynchronous reset out of GAP.
        run = 1'b0;
        do_reset("rst_gap");

        // Hold in IDLE until the next spawn will load 3C.
        cyc();
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (lfsr_step(model_lfsr) == 8'h3C) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        chk("t3_seek_3c", found, 1);
        run = 1'b1;
        cyc();
        push(EV_SPAWN, 8'h3C);
        cyc();
        chk("t3_letter", letter, 8'h3C);
        pulse_submit(8'h3D);
        chk("t3_wrong_no_pulse", correct, 0);
        chk("t3_wrong_ypos", ypos, 0);
        chk("t3_wrong_letter", letter, 8'h3C);
        cyc();
        push(EV_CORRECT, 8'h00);
        pulse_submit(8'h3C);
        chk("t3_hit", correct, 1);
        chk("t3_hit_letter", letter, 0);
        chk("t3_hit_active", active, 0);
        cyc();
        chk("t3_pulse_one_cycle", correct, 0);
        do_ticks(1);
        chk("t3_gap_empty", active, 0);
        do_ticks(1);
        saved_letter = model_lfsr;
        push(EV_SPAWN, saved_letter);
        cyc();
        chk("t3_respawn_active", active, 1);
        chk("t3_respawn_ypos", ypos, 0);

        // Hit on the same tick that would drop the target off row 19.
        do_ticks(76);
        chk("t4_ypos19", ypos, 19);
        do_ticks(3);
        chk("t4_cnt3_ypos", ypos, 19);
        push(EV_CORRECT, 8'h00);
        tick = 1'b1;
        pulse_submit(saved_letter);
        tick = 1'b0;
        chk("t4_hit", correct, 1);
        chk("t4_no_game_over", game_over, 0);
        cyc();
        cyc();
        chk("t4_gap_game_over", game_over, 0);
        chk("t4_gap_active", active, 0);
        do_ticks(2);
        push(EV_SPAWN, model_lfsr);
        cyc();
        chk("t4_respawn_active", active, 1);

        cyc();
        cyc();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
